// File: rtl/wrr_pointer_sel.sv
// Round-robin pointer and weight table feeding the weighted-round-robin grant stage.
// Presents a registered one-hot candidate and advances past each newly granted channel.
module wrr_pointer_sel #(
  parameter int unsigned CHANNELS       = 8,
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned DEFAULT_WEIGHT = 1,
  parameter int unsigned AW             = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] request,
  input  logic [CHANNELS-1:0] gnt,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [WIDTH-1:0]    cfg_wdata,
  output logic [CHANNELS-1:0] next_gnt,
  output logic [WIDTH-1:0]    weight,
  output logic [WIDTH-1:0]    grant_events
);

  localparam int unsigned PtrW = $clog2(CHANNELS);

  logic [WIDTH-1:0]    table_q [CHANNELS];
  logic [WIDTH-1:0]    table_d [CHANNELS];
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [CHANNELS-1:0] gnt_d_q;
  logic [CHANNELS-1:0] next_gnt_q, next_gnt_d;
  logic [WIDTH-1:0]    events_q, events_d;

  logic [CHANNELS-1:0] eligible, upper_mask, upper_elig, search_src;
  logic [PtrW-1:0]     g_idx, ng_idx;
  logic                gnt_event;

  // Lowest set bit wins, so multi-hot gnt resolves to its lowest channel.
  always_comb begin
    g_idx  = '0;
    ng_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (gnt[i])        g_idx  = PtrW'(i);
      if (next_gnt_q[i]) ng_idx = PtrW'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      table_d[i]  = table_q[i];
      eligible[i] = request[i] && (table_q[i] != '0);
      if (cfg_we && (cfg_addr == AW'(i))) table_d[i] = cfg_wdata;
    end
  end

  // Prefer eligible channels at or above ptr; otherwise wrap to the lowest eligible one.
  always_comb begin
    upper_mask = ~((CHANNELS'(1) << ptr_q) - CHANNELS'(1));
    upper_elig = eligible & upper_mask;
    search_src = (|upper_elig) ? upper_elig : eligible;
    next_gnt_d = search_src & (~search_src + CHANNELS'(1));
  end

  always_comb begin
    gnt_event = (|gnt) && (gnt != gnt_d_q);
    ptr_d     = ptr_q;
    events_d  = events_q;
    if (gnt_event) begin
      ptr_d    = (g_idx == PtrW'(CHANNELS - 1)) ? '0 : g_idx + PtrW'(1);
      events_d = events_q + WIDTH'(1);
    end
  end

  always_comb begin
    weight = '0;
    if (|gnt)            weight = table_q[g_idx];
    else if (|next_gnt_q) weight = table_q[ng_idx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q      <= '0;
      gnt_d_q    <= '0;
      next_gnt_q <= '0;
      events_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) table_q[i] <= WIDTH'(DEFAULT_WEIGHT);
    end else begin
      ptr_q      <= ptr_d;
      gnt_d_q    <= gnt;
      next_gnt_q <= next_gnt_d;
      events_q   <= events_d;
      for (int i = 0; i < CHANNELS; i++) table_q[i] <= table_d[i];
    end
  end

  assign next_gnt     = next_gnt_q;
  assign grant_events = events_q;

endmodule

// File: tb/tb_wrr_pointer_sel.sv
// Directed bench for wrr_pointer_sel: inputs driven and outputs sampled on the falling edge.
module tb_wrr_pointer_sel;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  request, gnt, next_gnt;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_wdata, weight, grant_events;
  int          n_run = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  // AW widened so an out-of-range address (8) is expressible.
  wrr_pointer_sel #(
    .CHANNELS      (8),
    .WIDTH         (32),
    .DEFAULT_WEIGHT(1),
    .AW            (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .request     (request),
    .gnt         (gnt),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .next_gnt    (next_gnt),
    .weight      (weight),
    .grant_events(grant_events)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0; request = '0; gnt = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    #3;
    n_run++;
    if (next_gnt !== 8'h00) begin
      n_fail++; $display("FAIL reset_next_gnt got %b want %b", next_gnt, 8'h00);
    end
    n_run++;
    if (grant_events !== 32'd0) begin
      n_fail++; $display("FAIL reset_events got %0d want 0", grant_events);
    end
    n_run++;
    if (weight !== 32'd0) begin
      n_fail++; $display("FAIL reset_weight got %0d want 0", weight);
    end
    tick(2);
    reset = 1'b1;
  endtask

  task automatic test_first_select;
    request = 8'b0000_0101;
    #1;
    n_run++;
    if (next_gnt !== 8'h00) begin
      n_fail++; $display("FAIL sel_no_comb_path got %b want %b", next_gnt, 8'h00);
    end
    tick(1);
    n_run++;
    if (next_gnt !== 8'b0000_0001) begin
      n_fail++; $display("FAIL sel_first got %b want %b", next_gnt, 8'b0000_0001);
    end
    n_run++;
    if (weight !== 32'd1) begin
      n_fail++; $display("FAIL sel_first_weight got %0d want 1", weight);
    end
  endtask

  task automatic test_grant_hold;
    gnt = 8'b0000_0001;
    tick(1);
    n_run++;
    if (next_gnt !== 8'b0000_0001) begin
      n_fail++; $display("FAIL hold_old_ptr got %b want %b", next_gnt, 8'b0000_0001);
    end
    tick(1);
    n_run++;
    if (next_gnt !== 8'b0000_0100) begin
      n_fail++; $display("FAIL hold_new_ptr got %b want %b", next_gnt, 8'b0000_0100);
    end
    tick(2);
    gnt = '0;
    tick(1);
    n_run++;
    if (grant_events !== 32'd1) begin
      n_fail++; $display("FAIL hold_single_event got %0d want 1", grant_events);
    end
    n_run++;
    if (weight !== 32'd1) begin
      n_fail++; $display("FAIL hold_weight_idle got %0d want 1", weight);
    end
  endtask

  task automatic test_zero_weight;
    request = 8'b0000_0100;
    cfg_we = 1'b1; cfg_addr = 4'd2; cfg_wdata = 32'd0;
    tick(1);
    cfg_we = 1'b0;
    tick(1);
    n_run++;
    if (next_gnt !== 8'h00) begin
      n_fail++; $display("FAIL zw_disabled got %b want %b", next_gnt, 8'h00);
    end
    n_run++;
    if (weight !== 32'd0) begin
      n_fail++; $display("FAIL zw_weight_zero got %0d want 0", weight);
    end
    cfg_we = 1'b1; cfg_addr = 4'd2; cfg_wdata = 32'd6;
    tick(1);
    cfg_we = 1'b0;
    tick(1);
    n_run++;
    if (next_gnt !== 8'b0000_0100) begin
      n_fail++; $display("FAIL zw_reenabled got %b want %b", next_gnt, 8'b0000_0100);
    end
    n_run++;
    if (weight !== 32'd6) begin
      n_fail++; $display("FAIL zw_weight_six got %0d want 6", weight);
    end
  endtask

  task automatic test_back_to_back;
    request = 8'b1000_0001;
    gnt = 8'b0100_0000;
    tick(1);
    gnt = 8'b1000_0000;
    tick(1);
    n_run++;
    if (next_gnt !== 8'b1000_0000) begin
      n_fail++; $display("FAIL b2b_ptr7 got %b want %b", next_gnt, 8'b1000_0000);
    end
    n_run++;
    if (grant_events !== 32'd3) begin
      n_fail++; $display("FAIL b2b_events got %0d want 3", grant_events);
    end
    tick(1);
    n_run++;
    if (next_gnt !== 8'b0000_0001) begin
      n_fail++; $display("FAIL b2b_wrap got %b want %b", next_gnt, 8'b0000_0001);
    end
    gnt = '0;
    tick(1);
  endtask

  task automatic test_bad_addr_multihot;
    cfg_we = 1'b1; cfg_addr = 4'd1; cfg_wdata = 32'd3;
    tick(1);
    cfg_addr = 4'd8; cfg_wdata = 32'd5;
    tick(1);
    cfg_we = 1'b0;
    request = 8'b0000_0111;
    gnt = 8'b0000_0110;
    #1;
    n_run++;
    if (weight !== 32'd3) begin
      n_fail++; $display("FAIL mh_weight got %0d want 3", weight);
    end
    tick(2);
    n_run++;
    if (next_gnt !== 8'b0000_0100) begin
      n_fail++; $display("FAIL mh_ptr2 got %b want %b", next_gnt, 8'b0000_0100);
    end
    gnt = 8'b0000_0001;
    #1;
    n_run++;
    if (weight !== 32'd1) begin
      n_fail++; $display("FAIL bad_addr_no_write got %0d want 1", weight);
    end
    tick(1);
    gnt = '0; request = '0;
    tick(1);
    n_run++;
    if (next_gnt !== 8'h00) begin
      n_fail++; $display("FAIL drop_clears got %b want %b", next_gnt, 8'h00);
    end
    n_run++;
    if (grant_events !== 32'd5) begin
      n_fail++; $display("FAIL drop_events got %0d want 5", grant_events);
    end
  endtask

  task automatic test_reset_mid;
    cfg_we = 1'b1; cfg_addr = 4'd3; cfg_wdata = 32'd9;
    request = 8'b0000_1000;
    gnt = 8'b0001_0000;
    tick(1);
    cfg_we = 1'b0;
    gnt = 8'b0000_1000;
    #1;
    n_run++;
    if (weight !== 32'd9) begin
      n_fail++; $display("FAIL rm_weight9 got %0d want 9", weight);
    end
    tick(1);
    gnt = 8'b0001_0000;
    tick(1);
    n_run++;
    if (grant_events !== 32'd8) begin
      n_fail++; $display("FAIL rm_events_pre got %0d want 8", grant_events);
    end
    reset = 1'b0;
    #1;
    n_run++;
    if (next_gnt !== 8'h00) begin
      n_fail++; $display("FAIL rm_next_gnt got %b want %b", next_gnt, 8'h00);
    end
    n_run++;
    if (grant_events !== 32'd0) begin
      n_fail++; $display("FAIL rm_events got %0d want 0", grant_events);
    end
    gnt = '0;
    tick(1);
    reset = 1'b1;
    tick(1);
    n_run++;
    if (next_gnt !== 8'b0000_1000) begin
      n_fail++; $display("FAIL rm_resume got %b want %b", next_gnt, 8'b0000_1000);
    end
    n_run++;
    if (weight !== 32'd1) begin
      n_fail++; $display("FAIL rm_table_reset got %0d want 1", weight);
    end
  endtask

  initial begin
    test_reset();
    test_first_select();
    test_grant_hold();
    test_zero_weight();
    test_back_to_back();
    test_bad_addr_multihot();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
